pc_unit: RTL

Program counter for the CPU fetch stage, sitting directly downstream of the 1-bit/16-bit register cells. It holds the current instruction address and advances it each cycle under load/increment/clear control. It optionally includes a small return-address stack for call/return sequencing. All state is edge-triggered on one clock, with an asynchronous active-low reset.

---
 rtl/pc_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with an optional return-address stack.
// Build option: define PC_STACK_EN to include the return stack; without it
// push/pop are ignored and the stack flags are tied to their idle values.
// Priority of the next address: clr > load > valid pop > inc > hold.

module pc_unit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    logic [WIDTH-1:0] out_inc;
    logic             pop_ok;
    logic [WIDTH-1:0] top_val;

    // Return address and increment both use the pre-edge out, wrapping mod 2^WIDTH.
    assign out_inc = out + 1'b1;

`ifdef PC_STACK_EN
    localparam int          PW       = $clog2(STACK_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(STACK_DEPTH);

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]    sp;        // next free slot; top lives at sp-1
    logic [PW:0]      depth;
    logic [PW-1:0]    top_idx;
    logic             is_empty;
    logic             is_full;
    logic             push_ok;
    logic             err_nxt;

    assign top_idx  = sp - 1'b1;
    assign top_val  = mem[top_idx];
    assign is_empty = (depth == '0);
    assign is_full  = (depth == FULL_CNT);
    assign pop_ok   = pop && !is_empty;
    // A push alongside a valid pop is a swap of the top entry, so it never overflows.
    assign push_ok  = push && (!is_full || pop_ok);
    assign err_nxt  = (pop && is_empty) || (push && is_full && !pop_ok);

    // Stack pointer, depth and the registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            stack_err <= err_nxt;
            if (push_ok && !pop_ok) begin
                sp    <= sp + 1'b1;
                depth <= depth + 1'b1;
            end else if (pop_ok && !push_ok) begin
                sp    <= top_idx;
                depth <= depth - 1'b1;
            end
        end
    end

    // Stack storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            if (pop_ok) mem[top_idx] <= out_inc;
            else        mem[sp]      <= out_inc;
        end
    end

    assign stack_empty = is_empty;
    assign stack_full  = is_full;
`else
    logic unused_stack;
    assign unused_stack = ^{push, pop};

    assign pop_ok      = 1'b0;
    assign top_val     = '0;
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;
`endif

    // Program counter register with clr > load > pop > inc > hold priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (clr) begin
            out <= '0;
        end else if (load) begin
            out <= in;
        end else if (pop_ok) begin
            out <= top_val;
        end else if (inc) begin
            out <= out_inc;
        end
    end

endmodule
